// File: rtl/add_stream_accum_if.sv
// Bundle of the sample stream, adder operand/result and packet-result handshake
// signals that connect add_stream_accum to its source, adder and sink.
interface add_stream_accum_if #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_o;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_sum;
  logic [COUNT_W-1:0] out_count;
  logic               out_ovf;

  // The accumulator is the slave; the surrounding environment is the master.
  modport slave (
    input  flush, in_valid, in_data, in_last, add_o, out_ready,
    output in_ready, add_a, add_b, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output flush, in_valid, in_data, in_last, add_o, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/add_stream_accum.sv
// Packet accumulator feeding an external add_bNN adder; sums in_last-delimited
// packets and holds the sum, saturating beat count and sticky overflow until taken.
module add_stream_accum #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  add_stream_accum_if.slave   bus
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [COUNT_W-1:0] cnt_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_sum_q;
  logic [COUNT_W-1:0] out_count_q;
  logic               out_ovf_q;

  logic [COUNT_W-1:0] cnt_d;
  logic               ovf_d;
  logic               carry;
  logic               accept;

  assign bus.add_a     = acc_q;
  assign bus.add_b     = bus.in_data;
  assign bus.in_ready  = (state_q == ACC) && !bus.flush;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

  // add_o is only consumed under accept, so an undriven adder while idle is harmless.
  assign accept = bus.in_valid && bus.in_ready;
  assign carry  = (bus.add_o < acc_q);
  assign ovf_d  = ovf_q | carry;
  assign cnt_d  = (cnt_q == {COUNT_W{1'b1}}) ? cnt_q
                                             : cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (bus.flush) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end else if (accept) begin
            acc_q <= bus.add_o;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (bus.in_last) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_sum_q   <= bus.add_o;
              out_count_q <= cnt_d;
              out_ovf_q   <= ovf_d;
            end
          end
        end
        HOLD: begin
          // Result stays frozen here; flush has no effect until the sink takes it.
          if (bus.out_ready) begin
            state_q     <= ACC;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

endmodule
